dtw_mem_reader: RTL and testbench
=================================

Name: dtw_mem_reader

Overview:
- Read-side initiator for the shared single-port synchronous template memory (10-bit address, 32-bit bidirectional data bus, active-low chip select, WR 0 = read / 1 = write).
- On a start command it fetches a contiguous block of words from a base address and streams them out in address order over a valid/ready interface.
- Feeds stored template (R) sequences into the DTW processor.
- It is the counterpart of the memory responder: it generates `CS`, `WR` and the address, and samples the bus with the responder's fixed 1-cycle read latency.

Parameters:
- ADDR_W, 10, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 32, memory / stream word width.
- LEN_W, 6, width of the length field; maximum request is 2^LEN_W-1 words.
- FIFO_DEPTH, 4, output buffer entries; must be a power of 2 and at least 2.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request pulse; accepted only in IDLE.
- i_base_addr  input  ADDR_W  first word address, sampled when start is accepted.
- i_len  input  LEN_W  word count, sampled when start is accepted.
- o_busy  output  1  high while a request is in progress.
- o_done  output  1  1-cycle pulse when a request completes.
- o_mem_addr  output  ADDR_W  memory address.
- io_mem_data  inout  DATA_W  memory data bus; this block never drives it (permanently high-Z).
- o_mem_WR  output  1  tied 0 (read only).
- o_mem_CS  output  1  active-low chip select.
- o_data  output  DATA_W  stream word, taken from the FIFO head.
- o_valid  output  1  stream word present; equals (FIFO count != 0).
- i_ready  input  1  consumer accepts; a transfer occurs on any edge where o_valid && i_ready.

Behaviour:
- Reset values: o_mem_CS=1, o_mem_WR=0, o_mem_addr=0, o_valid=0, o_data=0, o_busy=0, o_done=0. On reset the FIFO empties and the in-flight flag, counters and state clear.
- Reset asserted mid-request aborts the request immediately (asynchronously). No done pulse is produced.
- States are IDLE, READ, DRAIN, DONE.
- IDLE: i_start=1 latches base/len into addr_q/remain_q.
  - len != 0: go to READ, o_busy=1 from the next cycle.
  - len == 0: go to DONE; no CS assertion.
  - i_start in any other state is ignored.
- Issue rule (READ): a word is issued in a cycle iff remain_q != 0 and (fifo_count + inflight) < FIFO_DEPTH. The check uses registered values with no pop credit.
  - Issuing drives o_mem_CS=0 and o_mem_addr=addr_q, sets inflight for the next cycle, then addr_q+1 (wraps 2^ADDR_W-1 to 0) and remain_q-1.
- Data capture: in any cycle where inflight=1, o_mem_CS is held 0 so the responder drives the bus. io_mem_data is sampled at that cycle's closing edge and pushed into the FIFO.
- o_mem_CS is 0 whenever issuing or inflight, else 1.
- o_mem_addr holds its last value when not issuing.
- A non-issue cycle with CS=0 (inflight only) is a harmless re-read and is never captured.
- Latency: start in cycle 0 gives addr issued in cycle 1, data on bus in cycle 2, o_valid=1 with that word in cycle 3. Sustained throughput is 1 word per cycle while i_ready=1.
- READ goes to DRAIN when remain_q hits 0 after the last issue.
- DRAIN goes to DONE when inflight=0 and the FIFO empties (the last pop happens on that edge).
- DONE: o_done=1 for exactly one cycle, o_busy=1 in that cycle, then IDLE with o_busy=0.
- FIFO: the issue rule guarantees no overflow. Simultaneous push and pop keeps the count unchanged. Pop on empty is impossible, since o_valid=0.
- Backpressure: with i_ready=0 at most FIFO_DEPTH words are buffered. Issue stalls, and CS returns to 1 once inflight clears. o_data/o_valid stay stable while o_valid && !i_ready.

Test Plan:
- Memory preloaded with MEM[i]=i+32'hA000_0000; start base=10'h010, len=20, i_ready=1.
  - Required: o_valid cycles 3..22 with data A000_0010..A000_0023 in order.
  - Required: CS low cycles 1..21, o_done pulse in cycle 23, o_mem_WR always 0.
- Wrap: base=10'h3FE, len=4 -> addresses 3FE,3FF,000,001 issued; words A000_03FE, A000_03FF, A000_0000, A000_0001.
- Backpressure: base=0, len=10, i_ready low for cycles 0..15, then high.
  - Required: exactly 4 words buffered, CS high after the 4th capture, o_data=A000_0000 held stable.
  - Required: afterwards all 10 words delivered in order, no loss or duplicate.
- len=0 -> o_done pulse in cycle 1, CS never asserted, o_valid never asserted.
- i_start re-pulsed mid-request with base=10'h200 -> ignored; original sequence completes unchanged.
- i_rst pulsed during a len=20 read after word 5 -> CS=1 and o_valid=0 immediately, no o_done.
  - Required: a following start (base=0, len=2) returns A000_0000, A000_0001.

Source files
------------

// File: rtl/dtw_mem_reader.sv
// Template memory read initiator: fetches a word block and streams it in address order.
// Start-to-first-word latency is 3 cycles; issue stalls on a full buffer, and CS releases once the last read lands.
module dtw_mem_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  inout  wire  [DATA_W-1:0] io_mem_data,
  output logic              o_mem_WR,
  output logic              o_mem_CS,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              pop;

  // Occupancy counts reads still on the bus so the buffer can never overflow.
  assign occupancy = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
  assign issue     = (state_q == S_READ) && (remain_q != '0) &&
                     (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign pop       = o_valid && i_ready;

  assign o_mem_CS   = !(issue || inflight_q);
  assign o_mem_addr = issue ? addr_q : mem_addr_q;
  assign o_mem_WR   = 1'b0;
  assign o_valid    = (fifo_cnt != '0);

  // io_mem_data is only ever sampled here; leaving it undriven keeps it high-Z.
  dtw_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push_vld (inflight_q),
    .push_dat (io_mem_data),
    .pop_vld  (pop),
    .head_dat (o_data),
    .count    (fifo_cnt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == S_IDLE && i_start) begin
        addr_q   <= i_base_addr;
        remain_q <= i_len;
      end else if (issue) begin
        addr_q     <= addr_q + ADDR_W'(1);
        remain_q   <= remain_q - LEN_W'(1);
        mem_addr_q <= addr_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = (i_len != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        o_busy = 1'b1;
        if (issue && remain_q == LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        // Finish on the edge that pops the last buffered word.
        if (!inflight_q && (fifo_cnt == '0 || (fifo_cnt == CNT_W'(1) && pop)))
          state_d = S_DONE;
      end
      S_DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// Small synchronous FIFO; head word is visible combinationally.
// Push and pop in the same cycle leave the count unchanged; caller must not overfill.
module dtw_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_vld) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_mem_reader.sv
// Directed bench for dtw_mem_reader with a 1-cycle-latency template memory model.
module tb_dtw_mem_reader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [9:0]  i_base_addr;
  logic [5:0]  i_len;
  logic        o_busy;
  logic        o_done;
  logic [9:0]  o_mem_addr;
  wire  [31:0] mem_bus;
  logic        o_mem_WR;
  logic        o_mem_CS;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;

  logic [31:0] rd_dat = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got_q[$];
  logic        cs_log    [64];
  logic        busy_log  [64];
  logic        valid_log [64];
  logic [9:0]  addr_log  [64];
  logic [31:0] data_log  [64];
  int          valid_first, cs_cnt, done_cyc, done_cnt;
  logic        wr_seen;

  always #5 i_clk = ~i_clk;

  dtw_mem_reader dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mem_addr  (o_mem_addr),
    .io_mem_data (mem_bus),
    .o_mem_WR    (o_mem_WR),
    .o_mem_CS    (o_mem_CS),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  // Responder: MEM[i] = A000_0000 + i, data appears the cycle after a CS-low read.
  assign mem_bus = rd_dat;
  always @(posedge i_clk)
    if (!o_mem_CS && !o_mem_WR) rd_dat <= 32'hA000_0000 + {22'b0, o_mem_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag, input logic [31:0] first, input int n);
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], first + 32'(i));
  endtask

  // Cycle 0 is the start cycle; every sample is taken at the falling edge.
  task automatic run_req(input logic [9:0] base, input logic [5:0] len, input int ncyc,
                         input int rdy_low_last, input int restart_cyc, input int rst_cyc);
    got_q.delete();
    valid_first = -1; cs_cnt = 0; done_cyc = -1; done_cnt = 0; wr_seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      if (c == rst_cyc + 1) i_rst = 1'b0;
      i_ready     = (c > rdy_low_last);
      i_start     = (c == 0) || (c == restart_cyc);
      i_base_addr = (c == 0) ? base : 10'h200;
      i_len       = (c == 0) ? len  : 6'd3;
      if (c == rst_cyc) begin
        i_rst = 1'b1;
        #1;
        check("rst_cs",    {31'b0, o_mem_CS}, 32'd1);
        check("rst_valid", {31'b0, o_valid},  32'd0);
        check("rst_busy",  {31'b0, o_busy},   32'd0);
      end
      cs_log[c]    = o_mem_CS;
      busy_log[c]  = o_busy;
      valid_log[c] = o_valid;
      addr_log[c]  = o_mem_addr;
      data_log[c]  = o_data;
      wr_seen      = wr_seen | o_mem_WR;
      if (!o_mem_CS) cs_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (o_valid && valid_first < 0) valid_first = c;
      if (o_valid && i_ready && !i_rst) got_q.push_back(o_data);
    end
    i_start = 1'b0;
  endtask

  initial begin
    int bad;
    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_ready = 1'b1;
    #1;
    check("reset_cs",    {31'b0, o_mem_CS}, 32'd1);
    check("reset_wr",    {31'b0, o_mem_WR}, 32'd0);
    check("reset_addr",  {22'b0, o_mem_addr}, 32'd0);
    check("reset_valid", {31'b0, o_valid},  32'd0);
    check("reset_data",  o_data,            32'd0);
    check("reset_busy",  {31'b0, o_busy},   32'd0);
    check("reset_done",  {31'b0, o_done},   32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Basic stream: base 0x010, len 20, consumer always ready.
    run_req(10'h010, 6'd20, 30, -1, -1, -1);
    check("basic_valid_first", 32'(valid_first), 32'd3);
    check("basic_valid_22",    {31'b0, valid_log[22]}, 32'd1);
    check("basic_valid_23",    {31'b0, valid_log[23]}, 32'd0);
    check("basic_cs_first",    {31'b0, cs_log[1]},  32'd0);
    check("basic_cs_0",        {31'b0, cs_log[0]},  32'd1);
    check("basic_cs_21",       {31'b0, cs_log[21]}, 32'd0);
    check("basic_cs_22",       {31'b0, cs_log[22]}, 32'd1);
    check("basic_cs_cnt",      32'(cs_cnt), 32'd21);
    check("basic_done_cyc",    32'(done_cyc), 32'd23);
    check("basic_done_cnt",    32'(done_cnt), 32'd1);
    check("basic_wr",          {31'b0, wr_seen}, 32'd0);
    check("basic_busy_0",      {31'b0, busy_log[0]},  32'd0);
    check("basic_busy_1",      {31'b0, busy_log[1]},  32'd1);
    check("basic_busy_23",     {31'b0, busy_log[23]}, 32'd1);
    check("basic_busy_24",     {31'b0, busy_log[24]}, 32'd0);
    check_words("basic", 32'hA000_0010, 20);

    // Address wrap at the top of memory.
    run_req(10'h3FE, 6'd4, 12, -1, -1, -1);
    check("wrap_addr1", {22'b0, addr_log[1]}, 32'h3FE);
    check("wrap_addr2", {22'b0, addr_log[2]}, 32'h3FF);
    check("wrap_addr3", {22'b0, addr_log[3]}, 32'h000);
    check("wrap_addr4", {22'b0, addr_log[4]}, 32'h001);
    check("wrap_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'hA000_03FE);
    check("wrap_w1", got_q.size() > 1 ? got_q[1] : 32'hX, 32'hA000_03FF);
    check("wrap_w2", got_q.size() > 2 ? got_q[2] : 32'hX, 32'hA000_0000);
    check("wrap_w3", got_q.size() > 3 ? got_q[3] : 32'hX, 32'hA000_0001);

    // Backpressure: consumer stalled for cycles 0..15.
    run_req(10'h000, 6'd10, 50, 15, -1, -1);
    bad = 0;
    for (int c = 1; c <= 15; c++) if (!cs_log[c]) bad++;
    check("bp_cs_low_cycles", 32'(bad), 32'd5);
    check("bp_cs_5", {31'b0, cs_log[5]}, 32'd0);
    check("bp_cs_6", {31'b0, cs_log[6]}, 32'd1);
    bad = 0;
    for (int c = 3; c <= 15; c++) if (!valid_log[c] || data_log[c] !== 32'hA000_0000) bad++;
    check("bp_head_hold", 32'(bad), 32'd0);
    check("bp_done_cnt", 32'(done_cnt), 32'd1);
    check_words("bp", 32'hA000_0000, 10);

    // Zero-length request.
    run_req(10'h055, 6'd0, 6, -1, -1, -1);
    check("len0_done_cyc", 32'(done_cyc), 32'd1);
    check("len0_done_cnt", 32'(done_cnt), 32'd1);
    check("len0_cs_cnt",   32'(cs_cnt), 32'd0);
    check("len0_valid",    32'(valid_first), 32'hFFFF_FFFF);

    // Second start during a request is ignored.
    run_req(10'h040, 6'd8, 20, -1, 4, -1);
    check("restart_done_cyc", 32'(done_cyc), 32'd11);
    check("restart_done_cnt", 32'(done_cnt), 32'd1);
    check("restart_busy_end", {31'b0, busy_log[19]}, 32'd0);
    check_words("restart", 32'hA000_0040, 8);

    // Reset after the fifth word aborts the request.
    run_req(10'h000, 6'd20, 20, -1, -1, 8);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_cs_end",   {31'b0, cs_log[19]}, 32'd1);
    check_words("abort", 32'hA000_0000, 5);
    run_req(10'h000, 6'd2, 10, -1, -1, -1);
    check("after_rst_done_cyc", 32'(done_cyc), 32'd5);
    check_words("after_rst", 32'hA000_0000, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
